s3g_packet_rx: RTL and testbench
================================

// Module: s3g_packet_rx
// PURPOSE
//  Parametrised S3G packet receiver; successor to the fixed single-byte receiver feeding the LED display.
//  Consumes UART bytes (rx_data/rx_done), frames 0xD5|len|payload|crc8, verifies CRC-8 and buffers up to MAX_PAYLOAD bytes.
//  Exposes a random-access payload read port and a valid/ack handshake to the command decoder.
// PARAMETERS
//  MAX_PAYLOAD   32        max payload bytes accepted; larger len -> ERR_LEN
//  ADDR_W        5         payload address width, >= clog2(MAX_PAYLOAD)
//  TIMEOUT_CYC   50000     inter-byte timeout in clk cycles (1 ms @ 50 MHz); used only with S3G_RX_TIMEOUT_EN
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous reset, active low
//  rx_data      in   8       byte from uart_transceiver
//  rx_done      in   1       1-cycle strobe, rx_data valid
//  pkt_valid    out  1       complete CRC-good packet held in buffer
//  pkt_ack      in   1       consumer releases buffer
//  pkt_len      out  8       payload length of held packet
//  rd_addr      in   ADDR_W  payload read address
//  rd_data      out  8       payload[rd_addr], combinational read
//  err_strobe   out  1       1-cycle pulse on any framing/CRC error
//  err_code     out  3       last error: 0 none,1 CRC,2 LEN,3 OVERRUN,4 TIMEOUT
//  err_count    out  16      saturating error counter
// BEHAVIOUR
//  Reset: pkt_valid=0, pkt_len=0, err_strobe=0, err_code=0, err_count=0, state=IDLE, crc=0.
//  States: IDLE -> LEN -> PAYLOAD -> CRC -> HOLD; transitions only on rx_done (except timeout/ack).
//  IDLE: byte==0xD5 -> LEN; any other byte silently discarded (no error).
//  LEN: 1..MAX_PAYLOAD -> latch len, clear crc, idx=0, PAYLOAD; 0 or >MAX_PAYLOAD -> ERR_LEN, IDLE.
//  PAYLOAD: write buf[idx], crc update, idx++; after byte idx==len-1 -> CRC.
//  CRC: byte==crc -> HOLD, pkt_valid=1 in cycle after that rx_done; mismatch -> ERR_CRC, IDLE.
//  CRC-8: Maxim/iButton, reflected poly 0x8C, init 0x00, over payload only (not 0xD5, not len).
//  HOLD: pkt_valid/pkt_len/buffer stable until pkt_ack; ack -> pkt_valid=0 next cycle, IDLE.
//  rx_done while HOLD: byte dropped, ERR_OVERRUN; packet kept. rx_done and pkt_ack same cycle: ack wins, byte dropped, ERR_OVERRUN.
//  Error: err_strobe 1 cycle, err_code updated same edge, err_count+1 saturating at 0xFFFF.
//  pkt_ack outside HOLD ignored. rst_n low mid-packet: immediate return to reset values; buffer contents undefined.
// CONFIGURATION
//  S3G_RX_TIMEOUT_EN defined: counter cleared on each rx_done; in LEN/PAYLOAD/CRC reaching TIMEOUT_CYC -> ERR_TIMEOUT, IDLE.
//  Not defined: no counter; receiver waits indefinitely; code 4 never produced.
// STRUCTURE
//  s3g_pkg: S3G_START=8'hD5, CRC poly 8'h8C, err code localparams, state encoding.
//  Sub-module s3g_crc8: comb next_crc = f(crc, byte), reused by future TX block.
//  Payload buffer: MAX_PAYLOAD x 8 register array/distributed RAM, async read.
// TESTING
//  D5 01 01 5E -> pkt_valid=1 one cycle after last rx_done, pkt_len=1, rd_data@0=0x01; ack -> valid=0.
//  D5 01 01 00 -> err_strobe pulse, err_code=1, err_count=1, pkt_valid stays 0.
//  D5 00 then D5 21 (MAX_PAYLOAD=32) -> two ERR_LEN, err_count=2; next good packet accepted.
//  Good packet, no ack, send 0x33 -> err_code=3, rd_data@0 unchanged, pkt_valid held.
//  Noise 00 FF D4 before D5 01 01 5E -> no errors, packet accepted.
//  With S3G_RX_TIMEOUT_EN, D5 02 01 then idle TIMEOUT_CYC -> err_code=4, IDLE; without macro: no error.

Source files
------------

// File: rtl/s3g_pkg.sv
// -----------------------------------------------------------------------------
// s3g_pkg
// Shared constants for the S3G packet path: frame start byte, CRC-8 polynomial,
// error codes, receiver state encoding and the CRC-8 byte-update helper.
// -----------------------------------------------------------------------------
package s3g_pkg;

  localparam logic [7:0] S3G_START    = 8'hD5;
  // Maxim/iButton CRC-8, reflected form of x^8+x^5+x^4+1
  localparam logic [7:0] S3G_CRC_POLY = 8'h8C;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CRC     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_HOLD    = 3'd4
  } rx_state_t;

  // One byte of reflected CRC-8: data is consumed LSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[7:1]};
      if (fb) begin
        c = c ^ S3G_CRC_POLY;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_crc8.sv
// -----------------------------------------------------------------------------
// s3g_crc8
// Combinational CRC-8 (Maxim/iButton) single-byte step, shared by RX and TX.
// Ports:
//   crc       in  8  running CRC value
//   data      in  8  byte to fold in
//   next_crc  out 8  CRC after folding in data
// -----------------------------------------------------------------------------
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] next_crc
);

  assign next_crc = crc8_update(crc, data);

endmodule

// File: rtl/s3g_packet_rx.sv
// -----------------------------------------------------------------------------
// s3g_packet_rx
// Frames UART bytes as 0xD5 | len | payload | crc8, checks the CRC over the
// payload and holds a good packet for the command decoder until acknowledged.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rx_data[7:0], rx_done   byte and its 1-cycle valid strobe
//   pkt_valid, pkt_ack      held-packet flag / consumer release
//   pkt_len[7:0]            payload length of the held packet
//   rd_addr, rd_data[7:0]   asynchronous payload read port
//   err_strobe              1-cycle pulse on any error
//   err_code[2:0]           last error (0 none,1 CRC,2 LEN,3 OVERRUN,4 TIMEOUT)
//   err_count[15:0]         saturating error counter
// Configuration macro: S3G_RX_TIMEOUT_EN enables the inter-byte timeout
// (TIMEOUT_CYC cycles); without it the receiver waits indefinitely.
// -----------------------------------------------------------------------------
module s3g_packet_rx
  import s3g_pkg::*;
#(
  parameter int MAX_PAYLOAD = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              pkt_valid,
  input  logic              pkt_ack,
  output logic [7:0]        pkt_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err_strobe,
  output logic [2:0]        err_code,
  output logic [15:0]       err_count
);

  localparam logic [7:0]    MAX_LEN_C  = 8'(MAX_PAYLOAD);
  localparam logic [ADDR_W:0] RD_LIM_C = (ADDR_W+1)'(MAX_PAYLOAD);

  rx_state_t         state_r, state_nxt_s;
  logic [7:0]        len_r;
  logic [ADDR_W-1:0] idx_r;
  logic [7:0]        crc_r, crc_nxt_s;
  logic [7:0]        buf_r [MAX_PAYLOAD];
  logic              pkt_valid_r, err_strobe_r;
  logic [2:0]        err_code_r;
  logic [15:0]       err_count_r;

  logic              len_ok_s, last_byte_s, tmo_hit_s;
  logic              err_s, len_we_s, pay_we_s;
  logic [2:0]        err_code_s;

  s3g_crc8 u_crc8 (
    .crc      (crc_r),
    .data     (rx_data),
    .next_crc (crc_nxt_s)
  );

  assign len_ok_s    = (rx_data != 8'd0) && (rx_data <= MAX_LEN_C);
  assign last_byte_s = (8'(idx_r) == (len_r - 8'd1));

`ifdef S3G_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             busy_s;

  // Only a partially received frame can time out.
  assign busy_s    = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CRC);
  assign tmo_hit_s = busy_s && !rx_done && (tmo_cnt_r == TMO_LAST_C);

  // Inter-byte idle counter, restarted by every byte and outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if (rx_done || !busy_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a timeout overrides any in-frame state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    if (rx_done && (rx_data == S3G_START)) state_nxt_s = ST_LEN;
                  else state_nxt_s = ST_IDLE;
      ST_LEN:     if (rx_done) state_nxt_s = len_ok_s ? ST_PAYLOAD : ST_IDLE;
                  else state_nxt_s = ST_LEN;
      ST_PAYLOAD: if (rx_done && last_byte_s) state_nxt_s = ST_CRC;
                  else state_nxt_s = ST_PAYLOAD;
      ST_CRC:     if (rx_done) state_nxt_s = (rx_data == crc_r) ? ST_HOLD : ST_IDLE;
                  else state_nxt_s = ST_CRC;
      ST_HOLD:    if (pkt_ack) state_nxt_s = ST_IDLE;
                  else state_nxt_s = ST_HOLD;
      default:    state_nxt_s = ST_IDLE;
    endcase
    if (tmo_hit_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Event decode: errors and datapath write enables.
  always_comb begin
    err_s      = 1'b0;
    err_code_s = ERR_NONE;
    len_we_s   = 1'b0;
    pay_we_s   = 1'b0;
    case (state_r)
      ST_LEN: begin
        if (rx_done && len_ok_s) begin
          len_we_s = 1'b1;
        end else if (rx_done) begin
          err_s      = 1'b1;
          err_code_s = ERR_LEN;
        end else begin
          len_we_s = 1'b0;
        end
      end
      ST_PAYLOAD: pay_we_s = rx_done;
      ST_CRC: begin
        if (rx_done && (rx_data != crc_r)) begin
          err_s      = 1'b1;
          err_code_s = ERR_CRC;
        end else begin
          err_s = 1'b0;
        end
      end
      // A byte arriving while a packet is held is lost, even alongside an ack.
      ST_HOLD: begin
        if (rx_done) begin
          err_s      = 1'b1;
          err_code_s = ERR_OVERRUN;
        end else begin
          err_s = 1'b0;
        end
      end
      default: err_s = 1'b0;
    endcase
    if (tmo_hit_s) begin
      err_s      = 1'b1;
      err_code_s = ERR_TIMEOUT;
    end else begin
      err_s = err_s;
    end
  end

  // Error reporting and packet-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_strobe_r <= 1'b0;
      err_code_r   <= ERR_NONE;
      err_count_r  <= 16'd0;
      pkt_valid_r  <= 1'b0;
    end else begin
      err_strobe_r <= err_s;
      pkt_valid_r  <= (state_nxt_s == ST_HOLD);
      if (err_s) begin
        err_code_r  <= err_code_s;
        err_count_r <= (err_count_r == 16'hFFFF) ? err_count_r : (err_count_r + 16'd1);
      end else begin
        err_code_r <= err_code_r;
      end
    end
  end

  // Length, write index, running CRC and payload buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r <= 8'd0;
      idx_r <= '0;
      crc_r <= 8'd0;
      for (int i = 0; i < MAX_PAYLOAD; i++) buf_r[i] <= 8'd0;
    end else if (len_we_s) begin
      len_r <= rx_data;
      idx_r <= '0;
      crc_r <= 8'd0;
    end else if (pay_we_s) begin
      buf_r[idx_r] <= rx_data;
      crc_r        <= crc_nxt_s;
      idx_r        <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      len_r <= len_r;
    end
  end

  assign pkt_valid  = pkt_valid_r;
  assign pkt_len    = len_r;
  assign err_strobe = err_strobe_r;
  assign err_code   = err_code_r;
  assign err_count  = err_count_r;
  assign rd_data    = ({1'b0, rd_addr} < RD_LIM_C) ? buf_r[rd_addr] : 8'd0;

endmodule

// File: tb/tb_s3g_packet_rx.sv
module tb_s3g_packet_rx;

  localparam int MAXP = 32;
  localparam int AW   = 5;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_done = 1'b0;
  logic          pkt_valid;
  logic          pkt_ack = 1'b0;
  logic [7:0]    pkt_len;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          err_strobe;
  logic [2:0]    err_code;
  logic [15:0]   err_count;

  s3g_packet_rx #(.MAX_PAYLOAD(MAXP), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .pkt_valid(pkt_valid), .pkt_ack(pkt_ack), .pkt_len(pkt_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .err_strobe(err_strobe),
    .err_code(err_code), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [2:0]  code;
    logic [15:0] count;
    logic [7:0]  len;
    logic [7:0]  d0;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        prev_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [7:0]  pay [32];

  // Scoreboard monitor: every error pulse and every new packet pops one entry.
  always @(negedge clk) begin
    if (err_strobe === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_err: got code %0d count %0d, required no event", err_code, err_count);
      end else begin
        mon_e = sb.pop_front();
        if (!mon_e.is_err || err_code !== mon_e.code || err_count !== mon_e.count) begin
          errors++;
          $display("FAIL sb_err: got err code %0d count %0d, required is_err=%0d code %0d count %0d",
                   err_code, err_count, mon_e.is_err, mon_e.code, mon_e.count);
        end
      end
    end
    if (pkt_valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pkt: got len %0d, required no event", pkt_len);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_err || pkt_len !== mon_e.len || rd_data !== mon_e.d0) begin
          errors++;
          $display("FAIL sb_pkt: got len %0d d0 %02h, required is_err=%0d len %0d d0 %02h",
                   pkt_len, rd_data, mon_e.is_err, mon_e.len, mon_e.d0);
        end
      end
    end
    prev_valid = pkt_valid;
  end

  function automatic logic [7:0] crc_ref(input logic [7:0] p [32], input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ p[i];
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_err(input logic [2:0] code);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.is_err = 1'b1; e.code = code; e.count = exp_cnt; e.len = 8'd0; e.d0 = 8'd0;
    sb.push_back(e);
  endtask

  task automatic push_pkt(input logic [7:0] len, input logic [7:0] d0);
    exp_t e;
    e.is_err = 1'b0; e.code = 3'd0; e.count = 16'd0; e.len = len; e.d0 = d0;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_good(input int n);
    push_pkt(8'(n), pay[0]);
    send_byte(8'hD5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_byte(pay[i]);
    send_byte(crc_ref(pay, n));
    checks++;
    if (pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL good_valid: got pkt_valid %b, required 1", pkt_valid);
    end
  endtask

  task automatic do_ack();
    @(posedge clk); #1; pkt_ack = 1'b1;
    @(posedge clk); #1; pkt_ack = 1'b0;
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: got pkt_valid %b, required 0", pkt_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {15'd0, pkt_valid}, 16'd0);
    chk("reset_len", {8'd0, pkt_len}, 16'd0);
    chk("reset_strobe", {15'd0, err_strobe}, 16'd0);
    chk("reset_code", {13'd0, err_code}, 16'd0);
    chk("reset_count", err_count, 16'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_good_packet();
    push_pkt(8'd1, 8'h01);
    send_byte(8'hD5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h5E);
    chk("good_valid", {15'd0, pkt_valid}, 16'd1);
    chk("good_len", {8'd0, pkt_len}, 16'd1);
    chk("good_data0", {8'd0, rd_data}, 16'h01);
    do_ack();
  endtask

  task automatic test_crc_error();
    push_err(3'd1);
    send_byte(8'hD5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    chk("crc_code", {13'd0, err_code}, 16'd1);
    chk("crc_count", err_count, 16'd1);
    repeat (2) @(posedge clk); #1;
    chk("crc_novalid", {15'd0, pkt_valid}, 16'd0);
  endtask

  task automatic test_len_error();
    push_err(3'd2);
    send_byte(8'hD5); send_byte(8'h00);
    push_err(3'd2);
    send_byte(8'hD5); send_byte(8'h21);
    chk("len_code", {13'd0, err_code}, 16'd2);
    chk("len_count", err_count, exp_cnt);
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    send_good(3);
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'(i); #1;
      chk("len_next_rd", {8'd0, rd_data}, {8'd0, pay[i]});
    end
    rd_addr = '0;
    do_ack();
  endtask

  task automatic test_overrun();
    pay[0] = 8'h12; pay[1] = 8'h34;
    send_good(2);
    push_err(3'd3);
    send_byte(8'h33);
    chk("ovr_code", {13'd0, err_code}, 16'd3);
    chk("ovr_valid", {15'd0, pkt_valid}, 16'd1);
    chk("ovr_len", {8'd0, pkt_len}, 16'd2);
    chk("ovr_data0", {8'd0, rd_data}, 16'h12);
    // ack and a byte in the same cycle: ack wins, byte is an overrun
    push_err(3'd3);
    @(posedge clk); #1;
    pkt_ack = 1'b1; rx_data = 8'hD5; rx_done = 1'b1;
    @(posedge clk); #1;
    pkt_ack = 1'b0; rx_done = 1'b0;
    chk("ovr_ack_valid", {15'd0, pkt_valid}, 16'd0);
    chk("ovr_ack_count", err_count, exp_cnt);
    pay[0] = 8'h5A;
    send_good(1);
    do_ack();
  endtask

  task automatic test_noise_and_ack_idle();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hD4);
    @(posedge clk); #1; pkt_ack = 1'b1;
    @(posedge clk); #1; pkt_ack = 1'b0;
    chk("noise_count", err_count, exp_cnt);
    chk("noise_valid", {15'd0, pkt_valid}, 16'd0);
    push_pkt(8'd1, 8'h01);
    send_byte(8'hD5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h5E);
    chk("noise_pkt", {15'd0, pkt_valid}, 16'd1);
    do_ack();
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 32; i++) pay[i] = 8'(i * 7 + 3);
    send_good(MAXP);
    chk("max_len", {8'd0, pkt_len}, 16'd32);
    rd_addr = AW'(31); #1;
    chk("max_rd31", {8'd0, rd_data}, {8'd0, pay[31]});
    rd_addr = AW'(16); #1;
    chk("max_rd16", {8'd0, rd_data}, {8'd0, pay[16]});
    rd_addr = '0;
    do_ack();
  endtask

  task automatic test_timeout();
    pay[0] = 8'h01; pay[1] = 8'h02;
`ifdef S3G_RX_TIMEOUT_EN
    push_err(3'd4);
`endif
    send_byte(8'hD5); send_byte(8'h02); send_byte(8'h01);
    repeat (TMO + 16) @(posedge clk);
    #1;
    chk("tmo_count", err_count, exp_cnt);
    chk("tmo_valid", {15'd0, pkt_valid}, 16'd0);
`ifdef S3G_RX_TIMEOUT_EN
    chk("tmo_code", {13'd0, err_code}, 16'd4);
    send_good(2);
`else
    push_pkt(8'd2, 8'h01);
    send_byte(8'h02);
    send_byte(crc_ref(pay, 2));
    chk("notmo_valid", {15'd0, pkt_valid}, 16'd1);
`endif
    do_ack();
  endtask

  task automatic test_reset_mid();
    send_byte(8'hD5); send_byte(8'h02); send_byte(8'hAA);
    #2; rst_n = 1'b0; #1;
    chk("rstmid_count", err_count, 16'd0);
    chk("rstmid_code", {13'd0, err_code}, 16'd0);
    exp_cnt = 16'd0;
    @(posedge clk); #1; rst_n = 1'b1;
    pay[0] = 8'h77; pay[1] = 8'h88;
    send_good(2);
    do_ack();
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_crc_error();
    test_len_error();
    test_overrun();
    test_noise_and_ack_idle();
    test_max_len();
    test_timeout();
    test_reset_mid();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
